// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter for the single block-RAM data port, CPU priority.
// Define ARB_STARVE_GUARD_EN to build the DMA starvation guard (wait_cnt).
module mem_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DMA
    } owner_e;

    typedef enum logic [1:0] {
        LG_IDLE,
        LG_CPU,
        LG_DMA
    } last_e;

    owner_e rd_owner;
    owner_e rd_owner_nx;
    last_e  last_gnt;
    last_e  last_gnt_nx;
    logic   force_dma;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;
    logic [3:0] wait_cnt_nx;

    assign force_dma = dma_req && (wait_cnt == WAIT_MAX);

    always_comb begin
        wait_cnt_nx = wait_cnt;
        if (!dma_req || dma_gnt) begin
            wait_cnt_nx = '0;
        end else if (wait_cnt < WAIT_MAX) begin
            wait_cnt_nx = wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nx;
        end
    end
`else
    assign force_dma = 1'b0;
`endif

    // last_gnt is kept for debug visibility only
    logic unused;
    assign unused = ^{last_gnt, 4'(MAX_WAIT)};

    always_comb begin
        cpu_gnt = reset && cpu_req && !force_dma;
        dma_gnt = reset && dma_req && !cpu_gnt;
    end

    always_comb begin
        mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
        mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
        mem_we    = 1'b0;
        if (cpu_gnt) begin
            mem_we = cpu_we;
        end else if (dma_gnt) begin
            mem_we = dma_we;
        end
    end

    always_comb begin
        rd_owner_nx = OWN_NONE;
        last_gnt_nx = LG_IDLE;
        if (cpu_gnt) begin
            last_gnt_nx = LG_CPU;
            if (!cpu_we) rd_owner_nx = OWN_CPU;
        end else if (dma_gnt) begin
            last_gnt_nx = LG_DMA;
            if (!dma_we) rd_owner_nx = OWN_DMA;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner <= OWN_NONE;
            last_gnt <= LG_IDLE;
        end else begin
            rd_owner <= rd_owner_nx;
            last_gnt <= last_gnt_nx;
        end
    end

    // RAM data is already one cycle late, so it lines up with the tag
    assign cpu_rvalid = (rd_owner == OWN_CPU);
    assign dma_rvalid = (rd_owner == OWN_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 1-cycle RAM model.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, mem_we;

    typedef struct {
        bit          dma;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [15:0] ram [256];
    int          n_run = 0;
    int          n_fail = 0;
    int          cyc = 0;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) ram[i] <= {8'hA5, 8'(i)};
            ram[8'h40] <= 16'h1234;
            ram[8'hFF] <= 16'hFFFF;
        end else begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("rv_cpu", 32'(cpu_rvalid), 32'(!e.dma));
            chk("rv_dma", 32'(dma_rvalid), 32'(e.dma));
            chk("rdata", 32'(e.dma ? dma_rdata : cpu_rdata), 32'(e.data));
        end else begin
            chk("rv_cpu_idle", 32'(cpu_rvalid), 32'd0);
            chk("rv_dma_idle", 32'(dma_rvalid), 32'd0);
            chk("rd_cpu_idle", 32'(cpu_rdata), 32'd0);
            chk("rd_dma_idle", 32'(dma_rdata), 32'd0);
        end
    end

    task automatic drive(input logic cr, input logic cw,
                         input logic [15:0] ca, input logic [15:0] cd,
                         input logic dr, input logic dw,
                         input logic [15:0] da, input logic [15:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    endtask

    task automatic exp_cyc(string tag, bit ec, bit ed, bit ew);
        @(negedge clk);
        chk({tag, "_cgnt"}, 32'(cpu_gnt), 32'(ec));
        chk({tag, "_dgnt"}, 32'(dma_gnt), 32'(ed));
        chk({tag, "_we"}, 32'(mem_we), 32'(ew));
        if (ec && !cpu_we) q.push_back('{1'b0, ram[cpu_addr[7:0]], cyc + 1});
        if (ed && !dma_we) q.push_back('{1'b1, ram[dma_addr[7:0]], cyc + 1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1, 0, 16'h00FF, 16'h0, 1, 0, 16'h0077, 16'h0);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_cyc("rst", 0, 0, 0);
        tick();
        reset = 1'b1;
        exp_cyc("rel", 1, 0, 0);
        tick();

        drive(1, 0, 16'h0040, 16'h0, 0, 0, 16'h0, 16'h0);
        exp_cyc("rd", 1, 0, 0);
        chk("rd_addr", 32'(mem_addr), 32'h0040);
        tick();
        idle();
        exp_cyc("rd_ret", 0, 0, 0);
        tick();

        drive(1, 0, 16'h0050, 16'h0, 0, 0, 16'h0, 16'h0);
        exp_cyc("il_a", 1, 0, 0);
        tick();
        drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0060, 16'h0);
        exp_cyc("il_b", 0, 1, 0);
        chk("il_addr", 32'(mem_addr), 32'h0060);
        tick();
        idle();
        exp_cyc("il_ret", 0, 0, 0);
        tick();

        drive(1, 1, 16'h0010, 16'hBEEF, 1, 0, 16'h0020, 16'h0);
        exp_cyc("ct_n", 1, 0, 1);
        chk("ct_wdata", 32'(mem_wdata), 32'hBEEF);
        chk("ct_addr", 32'(mem_addr), 32'h0010);
        tick();
        drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0020, 16'h0);
        exp_cyc("ct_n1", 0, 1, 0);
        tick();
        drive(1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0);
        exp_cyc("ct_rb", 1, 0, 0);
        chk("ct_land", 32'(ram[8'h10]), 32'hBEEF);
        tick();

        for (int i = 1; i <= 4; i++) begin
            drive(1, 0, 16'(16'h0040 + i), 16'h0, 0, 0, 16'h0, 16'h0);
            exp_cyc("b2b", 1, 0, 0);
            tick();
        end
        drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0045, 16'h0);
        exp_cyc("b2b_d", 0, 1, 0);
        tick();
        idle();
        exp_cyc("b2b_end", 0, 0, 0);
        tick();

        drive(1, 0, 16'h0080, 16'h0, 1, 0, 16'h0090, 16'h0);
`ifdef ARB_STARVE_GUARD_EN
        for (int k = 1; k <= 12; k++) begin
            exp_cyc("starve", (k % (MW + 1)) != 0, (k % (MW + 1)) == 0, 0);
            if (k == MW + 2) chk("wait_clr", 32'(dut.wait_cnt), 32'd0);
            tick();
        end
`else
        for (int k = 1; k <= 100; k++) begin
            exp_cyc("starve", 1, 0, 0);
            tick();
        end
`endif
        idle();
        exp_cyc("starve_end", 0, 0, 0);
        tick();

        drive(0, 0, 16'h0, 16'h0, 1, 0, 16'h0030, 16'h0);
        exp_cyc("mr", 0, 1, 0);
        #1;
        reset = 1'b0;
        q.delete();
        tick();
        exp_cyc("mr_rst", 0, 0, 0);
        tick();
        idle();
        reset = 1'b1;
        exp_cyc("mr_rel", 0, 0, 0);
        tick();
        exp_cyc("mr_post", 0, 0, 0);
        tick();

        chk("drain", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
